// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
//
// Contents:
//   WIDTH_DEFAULT        - default datapath/address width
//   RESET_VECTOR_DEFAULT - PC loaded on reset
//   NOP_WORD_DEFAULT     - bubble instruction (sll $0,$0,0)
//   ifid_t               - IF/ID pipeline register fields; later pipeline
//                          registers reuse the same layout
//   align_word()         - clears the byte-offset bits of an address
package mips_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [WIDTH_DEFAULT-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0]              NOP_WORD_DEFAULT     = 32'h0000_0000;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] pc;
        logic [WIDTH_DEFAULT-1:0] pc_plus4;
        logic [31:0]              instr;
        logic                     valid;
    } ifid_t;

    function automatic logic [WIDTH_DEFAULT-1:0] align_word(input logic [WIDTH_DEFAULT-1:0] addr);
        return {addr[WIDTH_DEFAULT-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//
// Priority per rising edge: rst, then flush (bubble), then stall (hold),
// otherwise load d.
//
// Ports:
//   clk   - pipeline clock
//   rst   - synchronous active-high reset
//   stall - hold current contents
//   flush - insert a bubble; pc/pc_plus4 still load for debug visibility
//   d     - fields arriving from IF
//   q     - registered fields presented to ID
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.instr    <= NOP_WORD;
            q.valid    <= 1'b0;
        end else if (flush) begin
            // Flush beats stall: the bubble goes in even when IF is frozen.
            q.pc       <= d.pc;
            q.pc_plus4 <= d.pc_plus4;
            q.instr    <= NOP_WORD;
            q.valid    <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID register
// and a count of instructions delivered to ID.
//
// Next-PC priority: rst > redirect_valid > stall (hold) > nextPc.
// All outputs are registered.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   Adds output misalign_trap. A redirect whose target has nonzero [1:0]
//   loads the word-aligned target and pulses misalign_trap for one cycle.
//   Without the macro the redirect target is loaded verbatim.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall             - freeze PC and IF/ID
//   flush             - squash the instruction entering ID
//   redirect_valid    - taken branch/jump resolved in EX
//   redirect_target   - new PC on redirect
//   nextPc            - pc+4 from PC_Adder
//   imem_instr        - instruction read at pc
//   pc                - current fetch address
//   id_pc, id_pc_plus4, id_instr, id_valid - IF/ID contents
//   fetch_count       - valid instructions delivered to ID (wraps)
//   misalign_trap     - (optional) misaligned redirect pulse
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       WIDTH        = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0]       NOP_WORD     = NOP_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic [WIDTH-1:0] nextPc,
    input  logic [31:0]      imem_instr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic [31:0]      fetch_count
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic             misalign_trap
`endif
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] redirect_pc;
    logic [31:0]      fetch_count_q, fetch_count_d;
    logic             bubble;
    logic             fetch_fire;
    ifid_t            ifid_d, ifid_q;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    always_comb begin
        redirect_pc = align_word(redirect_target);
        trap_d      = redirect_valid && (redirect_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign misalign_trap = trap_q;
`else
    assign redirect_pc = redirect_target;
`endif

    // A redirect also squashes whatever IF fetched on the wrong path.
    assign bubble     = redirect_valid || flush;
    assign fetch_fire = !bubble && !stall;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (!stall) begin
            pc_d = nextPc;
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (fetch_fire) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = nextPc;
        ifid_d.instr    = imem_instr;
        ifid_d.valid    = 1'b1;
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (bubble),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign pc          = pc_q;
    assign id_pc       = ifid_q.pc;
    assign id_pc_plus4 = ifid_q.pc_plus4;
    assign id_instr    = ifid_q.instr;
    assign id_valid    = ifid_q.valid;
    assign fetch_count = fetch_count_q;

endmodule
